// File: rtl/data_frame_buffer.sv
// Multi-bank frame buffer: stores tlast-delimited sample frames, pairs each with a
// timing offset, and replays it from that offset behind a one-beat header.
module data_frame_buffer #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned SYN_DATA_WIDTH = 13,
  parameter int unsigned RAM_ADDR_WIDTH = 10,
  parameter int unsigned NUM_BANKS      = 2
) (
  input  logic                        axis_aclk,
  input  logic                        axis_arst,
  input  logic                        s_axis_ctrl_tvalid,
  input  logic                        s_axis_ctrl_tlast,
  input  logic [SYN_DATA_WIDTH-1:0]   s_axis_ctrl_tdata,
  output logic                        s_axis_ctrl_trdy,
  input  logic                        s_axis_data_tvalid,
  input  logic                        s_axis_data_tlast,
  input  logic [DATA_WIDTH-1:0]       s_axis_data_tdata,
  output logic                        s_axis_data_trdy,
  output logic                        m_axis_ctrl_tvalid,
  output logic                        m_axis_ctrl_tlast,
  output logic [RAM_ADDR_WIDTH+1:0]   m_axis_ctrl_tdata,
  input  logic                        m_axis_ctrl_trdy,
  output logic                        m_axis_data_tvalid,
  output logic                        m_axis_data_tlast,
  output logic [DATA_WIDTH-1:0]       m_axis_data_tdata,
  input  logic                        m_axis_data_trdy
);

  localparam int unsigned BW    = $clog2(NUM_BANKS);
  localparam int unsigned LW    = RAM_ADDR_WIDTH + 1;
  localparam int unsigned CW    = (SYN_DATA_WIDTH > LW) ? SYN_DATA_WIDTH : LW;
  localparam int unsigned DEPTH = 1 << RAM_ADDR_WIDTH;
  localparam int unsigned MW    = BW + RAM_ADDR_WIDTH;

  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_READING} bank_e;

  bank_e                     state_q  [NUM_BANKS];
  bank_e                     state_d  [NUM_BANKS];
  logic [LW-1:0]             len_q    [NUM_BANKS];
  logic [LW-1:0]             len_d    [NUM_BANKS];
  logic [SYN_DATA_WIDTH-1:0] offset_q [NUM_BANKS];
  logic [SYN_DATA_WIDTH-1:0] offset_d [NUM_BANKS];
  logic [NUM_BANKS-1:0]      ctrl_ok_q, ctrl_ok_d, ovf_q, ovf_d;
  logic [BW-1:0]             wp_q, wp_d, cp_q, cp_d, rp_q, rp_d;
  logic                      rd_active_q, rd_active_d, hdr_start_q, hdr_start_d;
  logic                      hdr_done_q, hdr_done_d, data_done_q, data_done_d;
  logic [LW-1:0]             rd_addr_q, rd_addr_d, rd_end_q, rd_end_d;
  logic                      ram_v_q, ram_v_d, ram_last_q, ram_last_d;
  logic [DATA_WIDTH-1:0]     ram_rdata_q;
  logic                      m_ctrl_tvalid_q, m_ctrl_tvalid_d;
  logic [LW:0]               m_ctrl_tdata_q, m_ctrl_tdata_d;
  logic                      out_v_q, out_v_d, out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;
  logic                      skid_v_q, skid_v_d, skid_last_q, skid_last_d;
  logic [DATA_WIDTH-1:0]     skid_data_q, skid_data_d;

  logic [DATA_WIDTH-1:0]     mem [NUM_BANKS*DEPTH];
  logic                      wr_en_c, rd_en_c;
  logic [MW-1:0]             wr_addr_c, rd_mem_addr_c;
  logic [LW-1:0]             wr_len_c, cnt_c;
  logic [CW-1:0]             off_ext_c, len_ext_c;
  logic [1:0]                occ_c;
  logic                      data_xfer_c, ctrl_xfer_c, m_ctrl_xfer_c, m_data_xfer_c;
  logic                      hdr_ok_c, dat_ok_c;
  logic                      unused_c;

  assign unused_c = s_axis_ctrl_tlast;

  assign s_axis_data_trdy = axis_arst &&
                            (state_q[wp_q] == B_FREE || state_q[wp_q] == B_FILLING);
  assign s_axis_ctrl_trdy = axis_arst && !ctrl_ok_q[cp_q] && (state_q[cp_q] != B_READING);

  assign data_xfer_c   = s_axis_data_tvalid && s_axis_data_trdy;
  assign ctrl_xfer_c   = s_axis_ctrl_tvalid && s_axis_ctrl_trdy;
  assign m_ctrl_xfer_c = m_ctrl_tvalid_q && m_axis_ctrl_trdy;
  assign m_data_xfer_c = out_v_q && m_axis_data_trdy;
  assign rd_mem_addr_c = {rp_q, rd_addr_q[RAM_ADDR_WIDTH-1:0]};

  // Next-state for bank bookkeeping, reader, header and output skid buffer
  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    offset_d        = offset_q;
    ctrl_ok_d       = ctrl_ok_q;
    ovf_d           = ovf_q;
    wp_d            = wp_q;
    cp_d            = cp_q;
    rp_d            = rp_q;
    rd_active_d     = rd_active_q;
    hdr_start_d     = 1'b0;
    hdr_done_d      = hdr_done_q;
    data_done_d     = data_done_q;
    rd_addr_d       = rd_addr_q;
    rd_end_d        = rd_end_q;
    ram_v_d         = 1'b0;
    ram_last_d      = ram_last_q;
    m_ctrl_tvalid_d = m_ctrl_tvalid_q;
    m_ctrl_tdata_d  = m_ctrl_tdata_q;
    out_v_d         = out_v_q;
    out_last_d      = out_last_q;
    out_data_d      = out_data_q;
    skid_v_d        = skid_v_q;
    skid_last_d     = skid_last_q;
    skid_data_d     = skid_data_q;
    wr_en_c         = 1'b0;
    wr_addr_c       = '0;
    wr_len_c        = '0;
    rd_en_c         = 1'b0;
    off_ext_c       = '0;
    len_ext_c       = '0;
    cnt_c           = '0;

    if (data_xfer_c) begin
      if (state_q[wp_q] == B_FREE) begin
        ovf_d[wp_q]   = 1'b0;
        state_d[wp_q] = B_FILLING;
      end else begin
        wr_len_c = len_q[wp_q];
      end
      // Beats past the bank depth are accepted but dropped
      if (wr_len_c < LW'(DEPTH)) begin
        wr_en_c     = 1'b1;
        wr_addr_c   = {wp_q, wr_len_c[RAM_ADDR_WIDTH-1:0]};
        len_d[wp_q] = wr_len_c + LW'(1);
      end else begin
        ovf_d[wp_q] = 1'b1;
      end
      if (s_axis_data_tlast) begin
        state_d[wp_q] = B_FULL;
        wp_d          = wp_q + BW'(1);
      end
    end

    if (ctrl_xfer_c) begin
      offset_d[cp_q]  = s_axis_ctrl_tdata;
      ctrl_ok_d[cp_q] = 1'b1;
      cp_d            = cp_q + BW'(1);
    end

    if (!rd_active_q && state_q[rp_q] == B_FULL && ctrl_ok_q[rp_q]) begin
      off_ext_c      = CW'(offset_q[rp_q]);
      len_ext_c      = CW'(len_q[rp_q]);
      cnt_c          = (off_ext_c >= len_ext_c) ? '0 : LW'(len_ext_c - off_ext_c);
      state_d[rp_q]  = B_READING;
      rd_active_d    = 1'b1;
      hdr_start_d    = 1'b1;
      hdr_done_d     = 1'b0;
      data_done_d    = (cnt_c == '0);
      rd_addr_d      = (cnt_c == '0) ? len_q[rp_q] : LW'(off_ext_c);
      rd_end_d       = len_q[rp_q];
      m_ctrl_tdata_d = {ovf_q[rp_q], cnt_c};
    end

    if (hdr_start_q) m_ctrl_tvalid_d = 1'b1;
    if (m_ctrl_xfer_c) begin
      m_ctrl_tvalid_d = 1'b0;
      hdr_done_d      = 1'b1;
    end

    // Issue a RAM read only if the skid buffer can absorb it whatever trdy does
    occ_c = 2'(out_v_q) + 2'(skid_v_q) + 2'(ram_v_q);
    if (rd_active_q && (rd_addr_q < rd_end_q) && ((occ_c < 2'd2) || m_data_xfer_c)) begin
      rd_en_c    = 1'b1;
      ram_v_d    = 1'b1;
      ram_last_d = (rd_addr_q + LW'(1) == rd_end_q);
      rd_addr_d  = rd_addr_q + LW'(1);
    end

    if (!out_v_q || m_data_xfer_c) begin
      if (skid_v_q) begin
        out_v_d     = 1'b1;
        out_data_d  = skid_data_q;
        out_last_d  = skid_last_q;
        skid_v_d    = ram_v_q;
        skid_data_d = ram_rdata_q;
        skid_last_d = ram_last_q;
      end else begin
        out_v_d    = ram_v_q;
        out_data_d = ram_rdata_q;
        out_last_d = ram_last_q;
      end
    end else if (ram_v_q) begin
      skid_v_d    = 1'b1;
      skid_data_d = ram_rdata_q;
      skid_last_d = ram_last_q;
    end

    hdr_ok_c = hdr_done_q || m_ctrl_xfer_c;
    dat_ok_c = data_done_q || (m_data_xfer_c && out_last_q);
    if (m_data_xfer_c && out_last_q) data_done_d = 1'b1;
    if (rd_active_q && hdr_ok_c && dat_ok_c) begin
      state_d[rp_q]   = B_FREE;
      ctrl_ok_d[rp_q] = 1'b0;
      rp_d            = rp_q + BW'(1);
      rd_active_d     = 1'b0;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_arst) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        state_q[i]  <= B_FREE;
        len_q[i]    <= '0;
        offset_q[i] <= '0;
      end
      ctrl_ok_q       <= '0;
      ovf_q           <= '0;
      wp_q            <= '0;
      cp_q            <= '0;
      rp_q            <= '0;
      rd_active_q     <= 1'b0;
      hdr_start_q     <= 1'b0;
      hdr_done_q      <= 1'b0;
      data_done_q     <= 1'b0;
      rd_addr_q       <= '0;
      rd_end_q        <= '0;
      ram_v_q         <= 1'b0;
      ram_last_q      <= 1'b0;
      m_ctrl_tvalid_q <= 1'b0;
      m_ctrl_tdata_q  <= '0;
      out_v_q         <= 1'b0;
      out_last_q      <= 1'b0;
      out_data_q      <= '0;
      skid_v_q        <= 1'b0;
      skid_last_q     <= 1'b0;
      skid_data_q     <= '0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      offset_q        <= offset_d;
      ctrl_ok_q       <= ctrl_ok_d;
      ovf_q           <= ovf_d;
      wp_q            <= wp_d;
      cp_q            <= cp_d;
      rp_q            <= rp_d;
      rd_active_q     <= rd_active_d;
      hdr_start_q     <= hdr_start_d;
      hdr_done_q      <= hdr_done_d;
      data_done_q     <= data_done_d;
      rd_addr_q       <= rd_addr_d;
      rd_end_q        <= rd_end_d;
      ram_v_q         <= ram_v_d;
      ram_last_q      <= ram_last_d;
      m_ctrl_tvalid_q <= m_ctrl_tvalid_d;
      m_ctrl_tdata_q  <= m_ctrl_tdata_d;
      out_v_q         <= out_v_d;
      out_last_q      <= out_last_d;
      out_data_q      <= out_data_d;
      skid_v_q        <= skid_v_d;
      skid_last_q     <= skid_last_d;
      skid_data_q     <= skid_data_d;
    end
  end

  // Sample RAM: one write port (writer), one registered read port (reader)
  always_ff @(posedge axis_aclk) begin
    if (wr_en_c) mem[wr_addr_c] <= s_axis_data_tdata;
    if (rd_en_c) ram_rdata_q <= mem[rd_mem_addr_c];
  end

  assign m_axis_ctrl_tvalid = m_ctrl_tvalid_q;
  assign m_axis_ctrl_tlast  = m_ctrl_tvalid_q;
  assign m_axis_ctrl_tdata  = m_ctrl_tdata_q;
  assign m_axis_data_tvalid = out_v_q;
  assign m_axis_data_tlast  = out_last_q;
  assign m_axis_data_tdata  = out_data_q;

endmodule

// File: tb/tb_data_frame_buffer.sv
// Bench for data_frame_buffer: directed and random frames checked against a
// frame-level reference model of headers and replayed samples.
module tb_data_frame_buffer;

  localparam int DW = 16, SW = 13, AW = 10, NB = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          axis_arst;
  logic          s_axis_ctrl_tvalid, s_axis_ctrl_tlast, s_axis_ctrl_trdy;
  logic [SW-1:0] s_axis_ctrl_tdata;
  logic          s_axis_data_tvalid, s_axis_data_tlast, s_axis_data_trdy;
  logic [DW-1:0] s_axis_data_tdata;
  logic          m_axis_ctrl_tvalid, m_axis_ctrl_tlast, m_axis_ctrl_trdy;
  logic [AW+1:0] m_axis_ctrl_tdata;
  logic          m_axis_data_tvalid, m_axis_data_tlast, m_axis_data_trdy;
  logic [DW-1:0] m_axis_data_tdata;

  always #5 clk = ~clk;

  data_frame_buffer #(
    .DATA_WIDTH(DW), .SYN_DATA_WIDTH(SW), .RAM_ADDR_WIDTH(AW), .NUM_BANKS(NB)
  ) dut (
    .axis_aclk(clk), .axis_arst(axis_arst),
    .s_axis_ctrl_tvalid(s_axis_ctrl_tvalid), .s_axis_ctrl_tlast(s_axis_ctrl_tlast),
    .s_axis_ctrl_tdata(s_axis_ctrl_tdata), .s_axis_ctrl_trdy(s_axis_ctrl_trdy),
    .s_axis_data_tvalid(s_axis_data_tvalid), .s_axis_data_tlast(s_axis_data_tlast),
    .s_axis_data_tdata(s_axis_data_tdata), .s_axis_data_trdy(s_axis_data_trdy),
    .m_axis_ctrl_tvalid(m_axis_ctrl_tvalid), .m_axis_ctrl_tlast(m_axis_ctrl_tlast),
    .m_axis_ctrl_tdata(m_axis_ctrl_tdata), .m_axis_ctrl_trdy(m_axis_ctrl_trdy),
    .m_axis_data_tvalid(m_axis_data_tvalid), .m_axis_data_tlast(m_axis_data_tlast),
    .m_axis_data_tdata(m_axis_data_tdata), .m_axis_data_trdy(m_axis_data_trdy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected header words {ovf,count} and data beats {last,sample}, in order
  logic [AW+1:0] exp_hq[$];
  logic [DW:0]   exp_dq[$];

  task automatic model_add(input int n, input int base, input int off);
    int len, cnt;
    logic ovf;
    len = (n > DEPTH) ? DEPTH : n;
    ovf = (n > DEPTH);
    cnt = (off >= len) ? 0 : len - off;
    exp_hq.push_back({ovf, (AW+1)'(cnt)});
    for (int a = off; a < len; a++) exp_dq.push_back({a == len - 1, DW'(base + a)});
  endtask

  int trdy_mode = 1;
  int first_hdr_cyc = -1, first_dat_cyc = -1, last_in_cyc = 0;
  logic [31:0] mon_exp;

  // Output sink: picks trdy for the coming edge, then scores that edge's transfers
  always @(negedge clk) begin
    case (trdy_mode)
      0: begin m_axis_data_trdy = 1'b0; m_axis_ctrl_trdy = 1'b0; end
      1: begin m_axis_data_trdy = 1'b1; m_axis_ctrl_trdy = 1'b1; end
      default: begin
        m_axis_data_trdy = 1'($urandom_range(0, 1));
        m_axis_ctrl_trdy = 1'($urandom_range(0, 1));
      end
    endcase
    if (axis_arst) begin
      if (m_axis_data_tvalid && first_dat_cyc < 0) first_dat_cyc = cyc;
      if (m_axis_ctrl_tvalid && first_hdr_cyc < 0) first_hdr_cyc = cyc;
      if (m_axis_data_tvalid && m_axis_data_trdy) begin
        if (exp_dq.size() != 0) mon_exp = 32'(exp_dq.pop_front());
        else mon_exp = '1;
        check_eq("data_beat", 32'({m_axis_data_tlast, m_axis_data_tdata}), mon_exp);
      end
      if (m_axis_ctrl_tvalid && m_axis_ctrl_trdy) begin
        check_eq("hdr_tlast", 32'(m_axis_ctrl_tlast), 32'd1);
        if (exp_hq.size() != 0) mon_exp = 32'(exp_hq.pop_front());
        else mon_exp = '1;
        check_eq("header", 32'(m_axis_ctrl_tdata), mon_exp);
      end
    end
  end

  int frames_done = 0, ctrls_done = 0;

  task automatic put_data(input logic [DW-1:0] d, input logic last);
    int g = 0;
    s_axis_data_tvalid = 1'b1; s_axis_data_tdata = d; s_axis_data_tlast = last;
    while (!s_axis_data_trdy && g < 4000) begin @(negedge clk); g++; end
    if (g >= 4000) check_eq("data_in_timeout", 32'(g), 32'd0);
    @(negedge clk);
    if (last) last_in_cyc = cyc;
    s_axis_data_tvalid = 1'b0; s_axis_data_tlast = 1'b0;
  endtask

  task automatic put_ctrl(input int off);
    int g = 0;
    s_axis_ctrl_tvalid = 1'b1; s_axis_ctrl_tdata = SW'(off); s_axis_ctrl_tlast = 1'b1;
    while (!s_axis_ctrl_trdy && g < 4000) begin @(negedge clk); g++; end
    if (g >= 4000) check_eq("ctrl_in_timeout", 32'(g), 32'd0);
    @(negedge clk);
    s_axis_ctrl_tvalid = 1'b0; s_axis_ctrl_tlast = 1'b0;
    ctrls_done++;
  endtask

  task automatic send_frame(input int n, input int base, input bit gaps);
    for (int i = 0; i < n; i++) begin
      put_data(DW'(base + i), i == n - 1);
      if (gaps && $urandom_range(0, 7) == 0) @(negedge clk);
    end
    frames_done++;
  endtask

  task automatic wait_drain(input int budget);
    int g = 0;
    while ((exp_dq.size() + exp_hq.size()) != 0 && g < budget) begin @(negedge clk); g++; end
    check_eq("drain", 32'(exp_dq.size() + exp_hq.size()), 32'd0);
    repeat (20) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctrl"}, 32'({m_axis_ctrl_tvalid, m_axis_ctrl_tlast, m_axis_ctrl_tdata,
                                  s_axis_ctrl_trdy, s_axis_data_trdy}), 32'd0);
    check_eq({tag, "_data"}, 32'({m_axis_data_tvalid, m_axis_data_tlast, m_axis_data_tdata}),
             32'd0);
  endtask

  int r_n[10], r_off[10], r_base[10];

  initial begin
    axis_arst = 1'b0;
    s_axis_ctrl_tvalid = 1'b0; s_axis_ctrl_tlast = 1'b0; s_axis_ctrl_tdata = '0;
    s_axis_data_tvalid = 1'b0; s_axis_data_tlast = 1'b0; s_axis_data_tdata = '0;
    m_axis_ctrl_trdy = 1'b0; m_axis_data_trdy = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    axis_arst = 1'b1;
    repeat (2) @(negedge clk);

    // 100-sample frame, offset 16 sent first; check header/data latency
    trdy_mode = 1; first_hdr_cyc = -1; first_dat_cyc = -1;
    model_add(100, 0, 16);
    put_ctrl(16);
    send_frame(100, 0, 0);
    wait_drain(500);
    check_eq("hdr_latency", 32'(first_hdr_cyc - last_in_cyc), 32'd2);
    check_eq("data_latency", 32'(first_dat_cyc - last_in_cyc), 32'd3);

    // Three 64-sample frames with the sink stalled until the writer backs up
    trdy_mode = 0; frames_done = 0;
    model_add(64, 16'h1000, 0);
    model_add(64, 16'h2000, 5);
    model_add(64, 16'h3000, 63);
    fork
      begin put_ctrl(0); put_ctrl(5); put_ctrl(63); end
      begin
        send_frame(64, 16'h1000, 0);
        send_frame(64, 16'h2000, 0);
        send_frame(64, 16'h3000, 0);
      end
      begin
        int g = 0;
        while (frames_done < 2 && g < 2000) begin @(negedge clk); g++; end
        repeat (8) @(negedge clk);
        check_eq("wr_stall_trdy", 32'(s_axis_data_trdy), 32'd0);
        check_eq("hdr_pending", 32'(m_axis_ctrl_tvalid), 32'd1);
        trdy_mode = 1;
      end
    join
    wait_drain(1000);

    // Oversized frame: samples past the bank depth are dropped, ovf reported
    model_add(1100, 0, 1000);
    put_ctrl(1000);
    send_frame(1100, 0, 0);
    wait_drain(500);

    // Offset beyond the frame: header only, then a normal frame
    model_add(100, 16'h0100, 200);
    put_ctrl(200);
    send_frame(100, 16'h0100, 0);
    model_add(50, 16'h0200, 3);
    put_ctrl(3);
    send_frame(50, 16'h0200, 0);
    wait_drain(500);

    // Random frames, offsets, input gaps and sink backpressure
    trdy_mode = 2;
    for (int k = 0; k < 10; k++) begin
      r_n[k]    = (k == 4) ? 1 : int'($urandom_range(1, 100));
      r_off[k]  = int'($urandom_range(0, 32'(r_n[k] + 4)));
      r_base[k] = int'($urandom_range(0, 16'hffff));
      model_add(r_n[k], r_base[k], r_off[k]);
    end
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          repeat ($urandom_range(0, 20)) @(negedge clk);
          put_ctrl(r_off[k]);
        end
      end
      begin
        for (int k = 0; k < 10; k++) begin
          repeat ($urandom_range(0, 5)) @(negedge clk);
          send_frame(r_n[k], r_base[k], 1);
        end
      end
    join
    wait_drain(5000);

    // Reset while one frame replays and the next is half written
    model_add(200, 16'h4000, 0);
    put_ctrl(0);
    send_frame(200, 16'h4000, 0);
    for (int i = 0; i < 30; i++) put_data(DW'(16'h5000 + i), 1'b0);
    #1 axis_arst = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    exp_dq.delete();
    exp_hq.delete();
    @(negedge clk);
    #1 axis_arst = 1'b1;
    @(negedge clk);
    trdy_mode = 1;
    model_add(80, 16'h6000, 7);
    put_ctrl(7);
    send_frame(80, 16'h6000, 0);
    wait_drain(500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
